muldiv: RTL and testbench

Iterative multiply/divide unit owning the HI/LO register pair. It sits beside the ALU in the execute stage and accepts operands on the same `num1`/`num2` convention, with `num1` as the multiplicand or dividend and `num2` as the multiplier or divisor. It performs long-latency MULT/MULTU/DIV/DIVU over many cycles behind a start/busy handshake, so the ALU stays single-cycle combinational.

---
 rtl/muldiv.sv | 160 ++++++++++++++++
 tb/tb_muldiv.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv.sv
// muldiv: iterative MULT/MULTU/DIV/DIVU unit owning HI/LO, start/busy handshake.
// Define MULDIV_FAST_MUL_EN for a single-cycle multiply path.
module muldiv (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] num1,
  input  logic [31:0] num2,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic        op_invalid,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINISH
  } state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic [31:0] a;
  logic [31:0] b;
  logic [63:0] acc;
  logic        is_div;
  logic        res_neg;
  logic        rem_neg;
  logic        dz;

  logic        sgn;
  logic        op_md;
  logic        op_mthi;
  logic        op_mtlo;
  logic        op_bad;
  logic [31:0] abs1;
  logic [31:0] abs2;

  always_comb begin
    sgn     = (op == 3'd0) || (op == 3'd2);
    op_md   = (op[2] == 1'b0);
    op_mthi = (op == 3'd4);
    op_mtlo = (op == 3'd5);
    op_bad  = (op[2:1] == 2'b11);
    abs1    = (sgn && num1[31]) ? -num1 : num1;
    abs2    = (sgn && num2[31]) ? -num2 : num2;
  end

  logic [32:0] mul_sum;
  logic [32:0] div_sh;
  logic        div_ge;
  logic [31:0] div_sub;
  logic [63:0] step_acc;

  // acc holds {partial product, multiplier} or {remainder, quotient}
  always_comb begin
    mul_sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, a} : 33'd0);
    div_sh  = {acc[63:32], acc[31]};
    div_ge  = (div_sh >= {1'b0, b});
    div_sub = div_sh[31:0] - b;
    if (is_div)
      step_acc = {div_ge ? div_sub : div_sh[31:0], acc[30:0], div_ge};
    else
      step_acc = {mul_sum, acc[31:1]};
  end

  logic [63:0] raw_prod;
  logic [63:0] p_fix;
  logic [31:0] q_fix;
  logic [31:0] r_fix;

  always_comb begin
`ifdef MULDIV_FAST_MUL_EN
    raw_prod = {32'd0, a} * {32'd0, b};
`else
    raw_prod = acc;
`endif
    p_fix = res_neg ? -raw_prod : raw_prod;
    q_fix = res_neg ? -acc[31:0] : acc[31:0];
    r_fix = rem_neg ? -acc[63:32] : acc[63:32];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 5'd0;
      a          <= 32'd0;
      b          <= 32'd0;
      acc        <= 64'd0;
      is_div     <= 1'b0;
      res_neg    <= 1'b0;
      rem_neg    <= 1'b0;
      dz         <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      div_zero   <= 1'b0;
      op_invalid <= 1'b0;
      hi         <= 32'd0;
      lo         <= 32'd0;
    end else begin
      done       <= 1'b0;
      div_zero   <= 1'b0;
      op_invalid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            unique case (1'b1)
              op_md: begin
                a       <= abs1;
                b       <= abs2;
                acc     <= {32'd0, op[1] ? abs1 : abs2};
                is_div  <= op[1];
                res_neg <= sgn & (num1[31] ^ num2[31]);
                rem_neg <= sgn & num1[31];
                dz      <= (num2 == 32'd0);
                cnt     <= 5'd31;
                busy    <= 1'b1;
`ifdef MULDIV_FAST_MUL_EN
                state   <= op[1] ? RUN : FINISH;
`else
                state   <= RUN;
`endif
              end
              op_mthi: hi <= num1;
              op_mtlo: lo <= num1;
              op_bad:  op_invalid <= 1'b1;
            endcase
          end
        end
        RUN: begin
          acc <= step_acc;
          cnt <= cnt - 5'd1;
          if (cnt == 5'd0)
            state <= FINISH;
        end
        FINISH: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
          if (is_div) begin
            if (dz) begin
              div_zero <= 1'b1;
            end else begin
              hi <= r_fix;
              lo <= q_fix;
            end
          end else begin
            hi <= p_fix[63:32];
            lo <= p_fix[31:0];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv.sv
// tb_muldiv: random + directed bench for muldiv against an
// arithmetic reference model with cycle-level output checking.
module tb_muldiv;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] num1 = 32'd0;
  logic [31:0] num2 = 32'd0;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic        op_invalid;
  logic [31:0] hi;
  logic [31:0] lo;

  int errors = 0;
  int checks = 0;

  muldiv dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .op         (op),
    .num1       (num1),
    .num2       (num2),
    .busy       (busy),
    .done       (done),
    .div_zero   (div_zero),
    .op_invalid (op_invalid),
    .hi         (hi),
    .lo         (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
               $time);
    end
  endtask

  function automatic logic [63:0] mul_ref(input logic [2:0] o,
      input logic [31:0] x, input logic [31:0] y);
    longint sx;
    longint sy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (o == 3'd0)
      return sx * sy;
    return {32'd0, x} * {32'd0, y};
  endfunction

  // returns {remainder, quotient}
  function automatic logic [63:0] div_ref(input logic [2:0] o,
      input logic [31:0] x, input logic [31:0] y);
    longint sx;
    longint sy;
    longint q;
    longint r;
    if (y == 32'd0)
      return 64'd0;
    if (o == 3'd2) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      q = sx / sy;
      r = sx % sy;
      return {r[31:0], q[31:0]};
    end
    return {x % y, x / y};
  endfunction

  // Reference model: expected outputs after each edge
  logic        m_busy, m_done, m_dz, m_inv;
  logic [31:0] m_hi, m_lo, m_phi, m_plo;
  logic        m_pdz;
  int          m_rem;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 0; m_done <= 0; m_dz <= 0; m_inv <= 0;
      m_hi <= 0; m_lo <= 0; m_phi <= 0; m_plo <= 0;
      m_pdz <= 0; m_rem <= 0;
    end else begin
      m_done <= 0;
      m_dz   <= 0;
      m_inv  <= 0;
      if (m_rem != 0) begin
        m_rem <= m_rem - 1;
        if (m_rem == 1) begin
          m_busy <= 0;
          m_done <= 1;
          if (m_pdz) begin
            m_dz <= 1;
          end else begin
            m_hi <= m_phi;
            m_lo <= m_plo;
          end
        end
      end else if (start) begin
        case (op)
          3'd0, 3'd1: begin
            {m_phi, m_plo} <= mul_ref(op, num1, num2);
            m_pdz  <= 0;
            m_rem  <= MUL_LAT;
            m_busy <= 1;
          end
          3'd2, 3'd3: begin
            {m_phi, m_plo} <= div_ref(op, num1, num2);
            m_pdz  <= (num2 == 32'd0);
            m_rem  <= DIV_LAT;
            m_busy <= 1;
          end
          3'd4: m_hi <= num1;
          3'd5: m_lo <= num1;
          default: m_inv <= 1;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", 64'(busy), 64'(m_busy));
    chk("done", 64'(done), 64'(m_done));
    chk("div_zero", 64'(div_zero), 64'(m_dz));
    chk("op_invalid", 64'(op_invalid), 64'(m_inv));
    chk("hi", 64'(hi), 64'(m_hi));
    chk("lo", 64'(lo), 64'(m_lo));
  end

  task automatic wait_idle(input string name, output int bc);
    bc = 0;
    while (busy && bc < 200) begin
      bc++;
      @(negedge clk);
    end
    if (bc >= 200)
      chk({name, "_timeout"}, 64'(bc), 64'd0);
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, output int bc);
    @(negedge clk);
    start = 1; op = o; num1 = x; num2 = y;
    @(negedge clk);
    start = 0; num1 = $urandom; num2 = $urandom;
    wait_idle("run_op", bc);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  int bc;

  initial begin
    // model pins against hand-computed values
    chk("ref_mult", mul_ref(3'd0, 32'hFFFF_FFFD, 32'd7),
        64'hFFFF_FFFF_FFFF_FFEB);
    chk("ref_multu", mul_ref(3'd1, 32'hFFFF_FFFD, 32'd7),
        64'h0000_0006_FFFF_FFEB);
    chk("ref_div", div_ref(3'd2, 32'hFFFF_FFF9, 32'd2),
        64'hFFFF_FFFF_FFFF_FFFD);
    chk("ref_ovf", div_ref(3'd2, 32'h8000_0000, 32'hFFFF_FFFF),
        64'h0000_0000_8000_0000);

    // reset with active inputs
    start = 1; op = 3'd4; num1 = 32'h1234; num2 = 32'h5;
    repeat (3) @(negedge clk);
    start = 0;
    rst_n = 1;
    @(negedge clk);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);

    run_op(3'd0, 32'hFFFF_FFFD, 32'd7, bc);
    chk("mult_lat", 64'(bc), 64'(MUL_LAT));
    chk("mult_done", 64'(done), 64'd1);
    chk("mult_res", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);

    run_op(3'd1, 32'hFFFF_FFFD, 32'd7, bc);
    chk("multu_res", {hi, lo}, 64'h0000_0006_FFFF_FFEB);

    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, bc);
    chk("div_lat", 64'(bc), 64'(DIV_LAT));
    chk("div_res", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

    run_op(3'd3, 32'd100, 32'd7, bc);
    chk("divu_res", {hi, lo}, 64'h0000_0002_0000_000E);

    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, bc);
    chk("div_ovf", {hi, lo}, 64'h0000_0000_8000_0000);

    run_op(3'd4, 32'h11, 32'd0, bc);
    chk("mthi_nobusy", 64'(bc), 64'd0);
    run_op(3'd5, 32'h22, 32'd0, bc);
    run_op(3'd3, 32'd5, 32'd0, bc);
    chk("dz_lat", 64'(bc), 64'(DIV_LAT));
    chk("dz_pulse", {62'd0, div_zero, done}, 64'd3);
    chk("dz_keep", {hi, lo}, 64'h0000_0011_0000_0022);

    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, bc);
    chk("fast_lat", 64'(bc), 64'(MUL_LAT));
    chk("multu_max", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

    run_op(3'd7, 32'h55, 32'h66, bc);
    chk("inv_keep", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

    // requests while busy are dropped
    @(negedge clk);
    start = 1; op = 3'd2; num1 = 32'hFFFF_FFF9; num2 = 32'd2;
    @(negedge clk);
    start = 0;
    repeat (3) @(negedge clk);
    start = 1; op = 3'd5; num1 = 32'hDEAD;
    @(negedge clk);
    op = 3'd0; num1 = 32'd3; num2 = 32'd3;
    @(negedge clk);
    start = 0;
    wait_idle("intf", bc);
    chk("intf_res", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

    // reset mid-operation
    @(negedge clk);
    start = 1; op = 3'd0; num1 = 32'd9; num2 = 32'd9;
    @(negedge clk);
    start = 0;
    repeat (9) @(negedge clk);
    rst_n = 0;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_hilo", {hi, lo}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (40) @(negedge clk);
    chk("abort_nodone", {hi, lo}, 64'd0);

    // random traffic, including holds that produce back-to-back accepts
    for (int i = 0; i < 250; i++) begin
      int hold;
      hold = ($urandom_range(0, 9) == 0) ? $urandom_range(30, 80)
                                          : $urandom_range(1, 3);
      for (int k = 0; k < hold; k++) begin
        start = 1;
        op = 3'($urandom_range(0, 7));
        num1 = pick();
        num2 = pick();
        @(negedge clk);
      end
      start = 0;
      num1 = $urandom;
      num2 = $urandom;
      repeat ($urandom_range(0, 40)) @(negedge clk);
    end
    wait_idle("final", bc);
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
